mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
Parametrised MEM-stage load/store unit for the 5-stage MIPS pipeline. It contains its own word-organised data memory and supports lw/lh/lhu/lb/lbu/sw/sh/sb with little-endian byte lanes and store-data forwarding from WB. It adds a configurable access latency with a pipeline stall handshake and raises registered address-error exceptions (AdEL/AdES). It sits between EX/MEM and MEM/WB. Its outputs feed WB and the hazard/exception unit.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the data memory (power of two)
LATENCY, 0, extra wait cycles per access (0..7); stall is held for LATENCY cycles
BASE_ADDR, 32'h00000000, byte address of word 0; valid range is BASE_ADDR .. BASE_ADDR+4*DEPTH_WORDS-1

Ports:
clk  input  1  pipeline clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  MEM-stage instruction valid
req_load  input  1  instruction is a load
req_store  input  1  instruction is a store
size  input  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word
uext  input  1  zero-extend load (lbu/lhu); ignored for word accesses and stores
addr  input  32  byte address (ALU result)
wdata_raw  input  32  store data from EX/MEM
fwd_sel  input  1  1 selects fwd_data as store data (WB→MEM forward)
fwd_data  input  32  WB result
pc  input  32  PC of the MEM-stage instruction
stall  output  1  holds IF..MEM while an access is waiting
rdata  output  32  extended load data, registered
rdata_valid  output  1  pulses with new rdata
exc_adel  output  1  load address error, one-cycle pulse
exc_ades  output  1  store address error, one-cycle pulse
exc_pc  output  32  PC of the faulting instruction, held until the next exception
pcplus8  output  32  pc+8, combinational (jal link value)

Behaviour:
- Reset values: stall=0, rdata=0, rdata_valid=0, exc_adel=0, exc_ades=0, exc_pc=0. FSM goes to IDLE and the wait counter is 0. Memory contents are not reset.
- An access occurs when req_valid=1 and (req_load or req_store). If both load and store are set, the request is a store.
- Misaligned accesses: half with addr[0]=1, or word with addr[1:0]≠0.
- Out-of-range accesses: addr outside the BASE_ADDR window.
- A misaligned or out-of-range request causes no memory access and no stall. In the next cycle the unit pulses exc_adel (load) or exc_ades (store) for one cycle and loads exc_pc with pc. rdata_valid stays 0.
- FSM states: IDLE, WAIT.
  - IDLE, legal access in cycle T, LATENCY=0: the access commits at the edge ending T. stall=0.
  - IDLE, legal access, LATENCY=N>0: go to WAIT with cnt=N-1. stall=1 combinationally in T, and stays 1 through cycle T+N-1.
  - WAIT: decrement cnt each cycle. When cnt=0, stall=0 and the access commits at the edge ending that cycle (T+N); return to IDLE.
- The pipeline holds all request inputs stable while stall=1. Inputs are re-sampled only on the commit edge.
- Store commit:
  - Store data = fwd_sel ? fwd_data : wdata_raw, sampled on the commit edge.
  - Word index = (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
  - sb writes lane addr[1:0] with data[7:0]; sh writes lanes {addr[1],0} and {addr[1],1} with data[15:0]; sw writes all lanes. Other lanes are unchanged.
- Load commit: on the commit edge rdata gets the extracted lane.
  - Bytes sign-extend from bit 7 unless uext=1.
  - Halves sign-extend from bit 15 unless uext=1.
  - rdata_valid=1 for exactly the next cycle; otherwise rdata holds its value.
- Back-to-back accesses are accepted in consecutive cycles when LATENCY=0. A load following a store to the same word returns the newly written data.
- Reset asserted in WAIT aborts the access: no write or read commits, and stall=0 from the next cycle.
- Non-access instructions (req_valid=0, or neither load nor store) leave all registered outputs unchanged except that the pulses (rdata_valid, exc_*) drop to 0.

Test Plan:
- LATENCY=0: sw 0xDEADBEEF at 0x10, then lw 0x10 → rdata=0xDEADBEEF, rdata_valid pulses 1 cycle, stall never asserted.
- Byte/half lanes: sw 0x11223344 at 0x20, sb 0xAA at 0x21, sh 0x8001 at 0x22. Then lw → 0x8001AA44; lb 0x22 → 0x00000001; lh 0x22 → 0xFFFF8001; lhu 0x22 → 0x00008001; lb 0x21 → 0xFFFFFFAA; lbu 0x21 → 0x000000AA.
- LATENCY=3: lw at cycle T → stall=1 in T..T+2, rdata_valid=1 in T+4. The same sequence with reset asserted at T+1 → no write/read, stall=0 at T+2.
- Forwarding: sw with wdata_raw=0x1, fwd_sel=1, fwd_data=0x55 → later lw returns 0x55.
- Exceptions: lh at 0x03 with pc=0x400 → exc_adel=1 next cycle only, exc_pc=0x400, memory unchanged. sw at BASE_ADDR+4*DEPTH_WORDS → exc_ades=1, no stall.
- pcplus8: pc=0xFFFFFFFC → pcplus8=0x00000004 (wrap-around).

Source files
------------

// File: rtl/mem_lsu_if.sv
// MEM-stage load/store request and response bundle between the pipeline and mem_lsu.
// The pipeline side drives requests; the unit returns stall, load data and exceptions.
interface mem_lsu_if;
    logic        req_valid;
    logic        req_load;
    logic        req_store;
    logic [1:0]  size;
    logic        uext;
    logic [31:0] addr;
    logic [31:0] wdata_raw;
    logic        fwd_sel;
    logic [31:0] fwd_data;
    logic [31:0] pc;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        exc_adel;
    logic        exc_ades;
    logic [31:0] exc_pc;
    logic [31:0] pcplus8;

    modport master (
        output req_valid, req_load, req_store, size, uext, addr,
               wdata_raw, fwd_sel, fwd_data, pc,
        input  stall, rdata, rdata_valid, exc_adel, exc_ades, exc_pc, pcplus8
    );

    modport slave (
        input  req_valid, req_load, req_store, size, uext, addr,
               wdata_raw, fwd_sel, fwd_data, pc,
        output stall, rdata, rdata_valid, exc_adel, exc_ades, exc_pc, pcplus8
    );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit with private word-organised data memory, little-endian
// byte lanes, WB store-data forwarding, configurable wait states and AdEL/AdES traps.
module mem_lsu #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic      clk,
    input  logic      reset,
    mem_lsu_if.slave  bus
);
    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic        HAS_WAIT = (LATENCY != 0);
    localparam logic [2:0]  CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state_r;
    logic [2:0]  cnt_r;
    logic [31:0] rdata_r;
    logic        rdata_valid_r;
    logic        exc_adel_r;
    logic        exc_ades_r;
    logic [31:0] exc_pc_r;
    logic [31:0] mem_r [DEPTH_WORDS];

    logic [31:0]   off_s;
    logic [AW-1:0] idx_s;
    logic          access_s;
    logic          store_s;
    logic          in_range_s;
    logic          misaligned_s;
    logic          legal_s;
    logic          stall_s;
    logic          commit_s;
    logic          error_s;
    logic [3:0]    be_s;
    logic [31:0]   wword_s;
    logic [31:0]   load_s;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return lo[0];
            default: return (lo != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the narrow store value onto every lane; the byte enables pick the target.
    function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] sz,
                                                 input logic [1:0] lo, input logic zext);
        logic [31:0] sh;
        sh = word >> {lo, 3'b000};
        case (sz)
            2'b00:   return zext ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return zext ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

    // Request decode, legality, stall and commit qualification
    always_comb begin
        off_s        = bus.addr - BASE_ADDR;
        idx_s        = off_s[AW+1:2];
        access_s     = bus.req_valid & (bus.req_load | bus.req_store);
        store_s      = bus.req_store;
        in_range_s   = ((off_s >> (AW + 2)) == 32'd0);
        misaligned_s = is_misaligned(bus.size, off_s[1:0]);
        legal_s      = access_s & in_range_s & ~misaligned_s;
        stall_s      = 1'b0;
        commit_s     = 1'b0;
        error_s      = 1'b0;
        case (state_r)
            IDLE: begin
                stall_s  = HAS_WAIT & legal_s;
                commit_s = ~HAS_WAIT & legal_s;
                error_s  = access_s & ~legal_s;
            end
            WAIT: begin
                // Inputs are frozen while waiting, so the request is still the legal one.
                stall_s  = (cnt_r != 3'd0);
                commit_s = (cnt_r == 3'd0) & legal_s;
            end
            default: begin
                stall_s  = 1'b0;
                commit_s = 1'b0;
            end
        endcase
        be_s    = lane_mask(bus.size, off_s[1:0]);
        wword_s = lane_data(bus.size, bus.fwd_sel ? bus.fwd_data : bus.wdata_raw);
        load_s  = lane_extract(mem_r[idx_s], bus.size, off_s[1:0], bus.uext);
    end

    // Access FSM, wait counter and registered load/exception outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            cnt_r         <= 3'd0;
            rdata_r       <= 32'h0000_0000;
            rdata_valid_r <= 1'b0;
            exc_adel_r    <= 1'b0;
            exc_ades_r    <= 1'b0;
            exc_pc_r      <= 32'h0000_0000;
        end else begin
            rdata_valid_r <= 1'b0;
            exc_adel_r    <= 1'b0;
            exc_ades_r    <= 1'b0;
            if (commit_s && !store_s) begin
                rdata_r       <= load_s;
                rdata_valid_r <= 1'b1;
            end
            if (error_s) begin
                exc_adel_r <= ~store_s;
                exc_ades_r <= store_s;
                exc_pc_r   <= bus.pc;
            end
            case (state_r)
                IDLE: begin
                    if (HAS_WAIT && legal_s) begin
                        state_r <= WAIT;
                        cnt_r   <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt_r == 3'd0) begin
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 3'd0;
                end
            endcase
        end
    end

    // Byte-lane store into the data memory; reset on the commit edge cancels the write
    always_ff @(posedge clk) begin
        if (!reset && commit_s && store_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wword_s[8*i +: 8];
                end
            end
        end
    end

    assign bus.stall       = stall_s;
    assign bus.rdata       = rdata_r;
    assign bus.rdata_valid = rdata_valid_r;
    assign bus.exc_adel    = exc_adel_r;
    assign bus.exc_ades    = exc_ades_r;
    assign bus.exc_pc      = exc_pc_r;
    assign bus.pcplus8     = bus.pc + 32'd8;
endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: a zero-latency instance and a three-wait-state
// instance, checked against a byte-addressed reference memory.
module tb_mem_lsu;
    localparam int unsigned DW = 64;
    localparam logic [31:0] B0 = 32'h0000_0000;
    localparam logic [31:0] B1 = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst0;
    logic        rst1;
    logic [1:0]  s_v;
    logic        s_load;
    logic        s_store;
    logic [1:0]  s_size;
    logic        s_uext;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_fs;
    logic [31:0] s_fwd;
    logic [31:0] s_pc;

    int npass = 0;
    int ntot  = 0;
    logic [7:0]  mdl [2][DW*4];
    logic [31:0] e_rdata [2];
    logic [31:0] e_pc [2];

    always #5 clk = ~clk;

    mem_lsu_if bus0();
    mem_lsu_if bus1();

    assign bus0.req_valid = s_v[0];
    assign bus0.req_load  = s_load;
    assign bus0.req_store = s_store;
    assign bus0.size      = s_size;
    assign bus0.uext      = s_uext;
    assign bus0.addr      = s_addr;
    assign bus0.wdata_raw = s_wdata;
    assign bus0.fwd_sel   = s_fs;
    assign bus0.fwd_data  = s_fwd;
    assign bus0.pc        = s_pc;
    assign bus1.req_valid = s_v[1];
    assign bus1.req_load  = s_load;
    assign bus1.req_store = s_store;
    assign bus1.size      = s_size;
    assign bus1.uext      = s_uext;
    assign bus1.addr      = s_addr;
    assign bus1.wdata_raw = s_wdata;
    assign bus1.fwd_sel   = s_fs;
    assign bus1.fwd_data  = s_fwd;
    assign bus1.pc        = s_pc;

    mem_lsu #(.DEPTH_WORDS(DW), .LATENCY(0), .BASE_ADDR(B0)) dut0 (.clk(clk), .reset(rst0), .bus(bus0));
    mem_lsu #(.DEPTH_WORDS(DW), .LATENCY(3), .BASE_ADDR(B1)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit legal(input logic [31:0] base, input logic [31:0] a, input int n);
        longint la, lb;
        la = longint'(a);
        lb = longint'(base);
        return (la >= lb) && (la < lb + 4 * longint'(DW)) && ((la % n) == 0);
    endfunction

    // Reference behaviour for the request currently on the inputs, applied at its commit.
    task automatic apply_model(input int w, output logic ev, output logic ea, output logic es);
        logic [31:0] base, data, val;
        int n, off;
        base = (w == 0) ? B0 : B1;
        n = nbytes(s_size);
        ev = 1'b0; ea = 1'b0; es = 1'b0;
        if (!(s_v[w] && (s_load || s_store))) return;
        if (!legal(base, s_addr, n)) begin
            es = s_store;
            ea = !s_store;
            e_pc[w] = s_pc;
            return;
        end
        off = int'(s_addr - base);
        if (s_store) begin
            data = s_fs ? s_fwd : s_wdata;
            for (int i = 0; i < n; i++) mdl[w][off+i] = data[8*i +: 8];
        end else begin
            val = 32'd0;
            for (int i = 0; i < n; i++) val |= 32'(mdl[w][off+i]) << (8*i);
            if (n < 4 && !s_uext && val[8*n-1]) val |= ~((32'd1 << (8*n)) - 32'd1);
            e_rdata[w] = val;
            ev = 1'b1;
        end
    endtask

    task automatic check_out(input int w, input logic ev, input logic ea, input logic es);
        logic [31:0] rd, xp;
        logic rv, ad, as;
        if (w == 0) begin
            rd = bus0.rdata; rv = bus0.rdata_valid; ad = bus0.exc_adel; as = bus0.exc_ades; xp = bus0.exc_pc;
        end else begin
            rd = bus1.rdata; rv = bus1.rdata_valid; ad = bus1.exc_adel; as = bus1.exc_ades; xp = bus1.exc_pc;
        end
        chk($sformatf("rdata_%0d", w), rd, e_rdata[w]);
        chk($sformatf("rdata_valid_%0d", w), 32'(rv), 32'(ev));
        chk($sformatf("exc_adel_%0d", w), 32'(ad), 32'(ea));
        chk($sformatf("exc_ades_%0d", w), 32'(as), 32'(es));
        chk($sformatf("exc_pc_%0d", w), xp, e_pc[w]);
    endtask

    // One-cycle request on instance w (no stall expected), outputs checked one cycle later.
    task automatic acc(input int w, input logic v, input logic ld, input logic st, input logic [1:0] sz,
                       input logic ux, input logic [31:0] a, input logic [31:0] wd,
                       input logic fs, input logic [31:0] fd, input logic [31:0] pc);
        logic ev, ea, es;
        s_load = ld; s_store = st; s_size = sz; s_uext = ux; s_addr = a;
        s_wdata = wd; s_fs = fs; s_fwd = fd; s_pc = pc; s_v[w] = v;
        #1;
        chk($sformatf("stall_%0d", w), 32'((w == 0) ? bus0.stall : bus1.stall), 32'd0);
        chk("pcplus8", (w == 0) ? bus0.pcplus8 : bus1.pcplus8, pc + 32'd8);
        apply_model(w, ev, ea, es);
        @(posedge clk); #1;
        s_v[w] = 1'b0;
        check_out(w, ev, ea, es);
    endtask

    // Legal access on the three-wait-state instance; optionally reset during the wait.
    task automatic acc_lat(input logic ld, input logic st, input logic [1:0] sz, input logic ux,
                           input logic [31:0] a, input logic [31:0] wd, input logic abort);
        logic ev, ea, es;
        s_load = ld; s_store = st; s_size = sz; s_uext = ux; s_addr = a;
        s_wdata = wd; s_fs = 1'b0; s_fwd = 32'd0; s_pc = 32'h0000_0200; s_v[1] = 1'b1;
        #1;
        chk("lat_stall_T", 32'(bus1.stall), 32'd1);
        ev = 1'b0; ea = 1'b0; es = 1'b0;
        if (!abort) apply_model(1, ev, ea, es);
        @(posedge clk); #1;
        chk("lat_stall_T1", 32'(bus1.stall), 32'd1);
        chk("lat_valid_T1", 32'(bus1.rdata_valid), 32'd0);
        if (abort) rst1 = 1'b1;
        @(posedge clk); #1;
        if (abort) begin
            rst1 = 1'b0;
            s_v[1] = 1'b0;
            e_rdata[1] = 32'd0;
            e_pc[1] = 32'd0;
            #1;
            chk("abort_stall_T2", 32'(bus1.stall), 32'd0);
            check_out(1, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
            check_out(1, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
            check_out(1, 1'b0, 1'b0, 1'b0);
        end else begin
            chk("lat_stall_T2", 32'(bus1.stall), 32'd1);
            @(posedge clk); #1;
            chk("lat_stall_T3", 32'(bus1.stall), 32'd0);
            chk("lat_valid_T3", 32'(bus1.rdata_valid), 32'd0);
            @(posedge clk); #1;
            s_v[1] = 1'b0;
            check_out(1, ev, ea, es);
        end
    endtask

    initial begin
        int kind, r;
        logic [31:0] a;
        logic ld, st, v;

        rst0 = 1'b1; rst1 = 1'b1; s_v = 2'b00;
        s_load = 1'b0; s_store = 1'b0; s_size = 2'd0; s_uext = 1'b0; s_addr = 32'd0;
        s_wdata = 32'd0; s_fs = 1'b0; s_fwd = 32'd0; s_pc = 32'd0;
        e_rdata[0] = 32'd0; e_rdata[1] = 32'd0; e_pc[0] = 32'd0; e_pc[1] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
        chk("reset_stall_0", 32'(bus0.stall), 32'd0);
        chk("reset_stall_1", 32'(bus1.stall), 32'd0);
        check_out(0, 1'b0, 1'b0, 1'b0);
        check_out(1, 1'b0, 1'b0, 1'b0);

        // Fill the zero-latency memory so every later load has a defined value.
        for (int i = 0; i < int'(DW); i++)
            acc(0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, B0 + 32'(4*i), $urandom, 1'b0, 32'd0, 32'h100);

        acc(0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'h104);
        acc(0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0, 32'd0, 32'h108);
        chk("lw_deadbeef", bus0.rdata, 32'hDEAD_BEEF);
        acc(0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0, 32'h10C);

        acc(0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, 1'b0, 32'd0, 32'h110);
        acc(0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AA, 1'b0, 32'd0, 32'h114);
        acc(0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_8001, 1'b0, 32'd0, 32'h118);
        acc(0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 1'b0, 32'd0, 32'h11C);
        chk("lw_lanes", bus0.rdata, 32'h8001_AA44);
        acc(0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h22, 32'd0, 1'b0, 32'd0, 32'h120);
        chk("lb_22", bus0.rdata, 32'h0000_0001);
        acc(0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 32'd0, 1'b0, 32'd0, 32'h124);
        chk("lh_22", bus0.rdata, 32'hFFFF_8001);
        acc(0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h22, 32'd0, 1'b0, 32'd0, 32'h128);
        chk("lhu_22", bus0.rdata, 32'h0000_8001);
        acc(0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h21, 32'd0, 1'b0, 32'd0, 32'h12C);
        chk("lb_21", bus0.rdata, 32'hFFFF_FFAA);
        acc(0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h21, 32'd0, 1'b0, 32'd0, 32'h130);
        chk("lbu_21", bus0.rdata, 32'h0000_00AA);

        acc(0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h0000_0001, 1'b1, 32'h0000_0055, 32'h134);
        acc(0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, 1'b0, 32'd0, 32'h138);
        chk("lw_forwarded", bus0.rdata, 32'h0000_0055);

        acc(0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 32'h03, 32'd0, 1'b0, 32'd0, 32'h400);
        chk("adel_pulse", 32'(bus0.exc_adel), 32'd1);
        chk("adel_pc", bus0.exc_pc, 32'h400);
        acc(0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0, 32'h404);
        chk("adel_drop", 32'(bus0.exc_adel), 32'd0);
        acc(0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, B0 + 32'(4*DW), 32'h1234_5678, 1'b0, 32'd0, 32'h408);
        chk("ades_pulse", 32'(bus0.exc_ades), 32'd1);
        acc(0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h00, 32'd0, 1'b0, 32'd0, 32'h40C);
        acc(0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 32'h24, 32'hA5A5_0F0F, 1'b0, 32'd0, 32'h410);
        acc(0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 32'h24, 32'd0, 1'b0, 32'd0, 32'h414);
        chk("size3_word", bus0.rdata, 32'hA5A5_0F0F);

        s_pc = 32'hFFFF_FFFC;
        #1;
        chk("pcplus8_wrap", bus0.pcplus8, 32'h0000_0004);
        @(posedge clk); #1;

        // Randomised back-to-back traffic on the zero-latency instance.
        for (int it = 0; it < 400; it++) begin
            kind = $urandom_range(0, 9);
            r = $urandom_range(0, 9);
            a = (r == 0) ? 32'($urandom) : B0 + 32'($urandom_range(0, 4*DW - 1));
            v = (kind != 9);
            ld = (kind <= 3) || (kind == 7);
            st = (kind >= 4) && (kind <= 7);
            acc(0, v, ld, st, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom,
                1'($urandom_range(0, 1)), $urandom, $urandom);
        end

        acc_lat(1'b0, 1'b1, 2'd2, 1'b0, B1 + 32'h40, 32'h1234_5678, 1'b0);
        acc_lat(1'b1, 1'b0, 2'd2, 1'b0, B1 + 32'h40, 32'd0, 1'b0);
        chk("lat_lw", bus1.rdata, 32'h1234_5678);
        acc(1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0, 32'h500);
        acc_lat(1'b0, 1'b1, 2'd2, 1'b0, B1 + 32'h40, 32'hCAFE_F00D, 1'b1);
        acc_lat(1'b1, 1'b0, 2'd2, 1'b0, B1 + 32'h40, 32'd0, 1'b1);
        acc_lat(1'b1, 1'b0, 2'd2, 1'b0, B1 + 32'h40, 32'd0, 1'b0);
        chk("abort_no_write", bus1.rdata, 32'h1234_5678);
        acc_lat(1'b1, 1'b0, 2'd1, 1'b0, B1 + 32'h42, 32'd0, 1'b0);
        chk("lat_lh", bus1.rdata, 32'h0000_1234);
        acc(1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, B1 + 32'(4*DW), 32'h1, 1'b0, 32'd0, 32'h600);
        chk("lat_ades", 32'(bus1.exc_ades), 32'd1);
        acc(1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, B1 + 32'h1, 32'd0, 1'b0, 32'd0, 32'h604);
        acc(1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, B1 - 32'h4, 32'd0, 1'b0, 32'd0, 32'h608);
        acc(1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0, 32'h60C);
        chk("lat_exc_pc_hold", bus1.exc_pc, 32'h608);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
